im_stage: RTL and testbench
===========================

// Module: im_stage
// PURPOSE
// - Memory stage of the 5-stage RV32I pipeline; consumes the IE/IM register driven by the execute stage.
// - Runs load/store accesses on a valid/ready data-memory port and stalls the pipeline while memory is not ready.
// - Returns the IM-stage ALU result to execute as its forwarding source.
// - Registers all write-back data and controls into the IM/IWB register.
// PARAMETERS
// - WIDTH        `WIDTH (32)        datapath / data-memory word width
// - ADDR_W       `I_ADD_SIZE (32)   PC-plus-4 width
// - RF_ADD_W     `RF_ADD_SIZE (5)   register-file address width
// PORTS
// - i_clk                  in   1         clock, rising edge
// - i_rstn                 in   1         asynchronous active-low reset
// - i_im_alu_out           in   WIDTH     ALU result from IE/IM; memory address
// - i_im_write_data        in   WIDTH     store data (forwarded rs2)
// - i_im_mem_we            in   1         store request
// - i_im_mem_re            in   1         load request
// - i_im_rf_we_ctrl        in   1         register-file write enable
// - i_im_rf_wb_src_ctrl    in   3         write-back source select, passed through
// - i_im_sx_data           in   WIDTH     immediate, passed through
// - i_im_pc_plus_4         in   ADDR_W    PC+4, passed through
// - i_im_dst               in   RF_ADD_W  destination register
// - i_dmem_ready           in   1         memory accepts/completes the access this cycle
// - i_dmem_rdata           in   WIDTH     load data; valid when i_dmem_ready=1
// - o_dmem_req             out  1         access request (combinational)
// - o_dmem_we              out  1         1 = write
// - o_dmem_addr            out  WIDTH     word-aligned address
// - o_dmem_wdata           out  WIDTH     write data
// - o_dmem_be              out  4         byte enables
// - o_m_alu_out            out  WIDTH     forwarding value to execute (= i_im_alu_out)
// - o_stall                out  1         freezes PC, IF/ID, ID/IE and IE/IM registers
// - o_iwb_alu_out, o_iwb_mem_rdata, o_iwb_sx_data  out  WIDTH   IM/IWB data
// - o_iwb_pc_plus_4        out  ADDR_W    IM/IWB PC+4
// - o_iwb_rf_we_ctrl       out  1         IM/IWB RF write enable
// - o_iwb_rf_wb_src_ctrl   out  3         IM/IWB write-back select
// - o_iwb_dst              out  RF_ADD_W  IM/IWB destination register
// BEHAVIOUR
// - Reset: FSM goes to IDLE; all o_iwb_* are 0; o_dmem_req and o_stall are 0.
// - access = i_im_mem_we | i_im_mem_re. When both are 1, the access is a write and the read is ignored.
// - FSM state IDLE:
//   - access=1: o_dmem_req=1 in the same cycle.
//   - i_dmem_ready=1 in that cycle: zero-wait access; stay in IDLE; o_stall=0.
//   - i_dmem_ready=0: o_stall=1; go to WAIT.
// - FSM state WAIT:
//   - Hold o_dmem_req=1 with all request fields constant; the stall keeps the IE/IM inputs stable.
//   - o_stall=1 until i_dmem_ready=1. In the ready cycle o_stall=0 and the FSM returns to IDLE.
// - IM/IWB register:
//   - Loaded on every edge where o_stall=0.
//   - While o_stall=1: capture a bubble (rf_we=0, dst=0); data fields don't-care.
//   - This guarantees exactly one RF write per instruction.
// - o_iwb_mem_rdata is captured from i_dmem_rdata on the completing edge of a load; otherwise it holds its value.
// - Access latency is 1 + N cycles for N wait cycles; a non-memory instruction has 1 cycle.
// - o_dmem_addr = {i_im_alu_out[WIDTH-1:2], 2'b00}.
// - o_m_alu_out is purely combinational and is valid during a stall.
// - Asynchronous reset during WAIT: the request is dropped immediately and the FSM returns to IDLE; memory must discard the access.
// CONFIGURATION
// - IM_STAGE_SUBWORD_EN defined:
//   - Adds input i_im_mem_size[2:0] (RV32I funct3).
//   - SB/SH: o_dmem_be from addr[1:0]; o_dmem_wdata is the data lane-replicated.
//   - LB/LH/LBU/LHU: the read lane is selected and sign- or zero-extended before capture.
// - Undefined:
//   - o_dmem_be=4'hF; words only; addr[1:0] is ignored.
// STRUCTURE
// - Shared package parameters.vh: FSM state encodings IM_IDLE/IM_WAIT and the funct3 size constants.
// - One sub-module, im_lsu_align: byte-enable generation, store lane replication, load extraction. It is only instantiated under IM_STAGE_SUBWORD_EN.
// TESTING
// 1. Store, ready=1 same cycle, addr=0x104, data=0xDEADBEEF:
//    - one cycle with req=1, we=1, addr=0x104, be=F; o_stall never asserted.
// 2. Load, ready low for 3 cycles then high, rdata=0x12345678:
//    - o_stall=1 for 3 cycles; three bubbles with rf_we=0; then o_iwb_mem_rdata=0x12345678 with rf_we=1 for exactly one cycle.
// 3. ALU op (no access), alu_out=0x55:
//    - o_m_alu_out=0x55 combinationally; o_iwb_alu_out=0x55 next edge; o_dmem_req=0.
// 4. i_rstn low during WAIT:
//    - req and stall drop asynchronously; all o_iwb_* are 0.
//    - After release, a new load completes normally.
// 5. we=1 and re=1 together:
//    - o_dmem_we=1; the captured rdata is unchanged.
// 6. (SUBWORD_EN) LB at addr 0x3, rdata=0x80AABBCC:
//    - be is ignored; o_iwb_mem_rdata=0xFFFFFF80.
//    - LBU gives 0x00000080; SH at addr 0x2 gives be=4'hC.

Source files
------------

// File: rtl/im_stage_pkg.sv
// Shared definitions for the memory stage: FSM state encodings and RV32I load/store funct3 codes.
// Also holds the byte-enable helper used by the sub-word aligner.
package im_stage_pkg;

   typedef enum logic [0:0] {
      IM_IDLE = 1'b0,
      IM_WAIT = 1'b1
   } im_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // funct3[1:0] carries the access width; funct3[2] only affects load extension
   function automatic logic [3:0] size_be(input logic [2:0] size, input logic [1:0] off);
      logic [3:0] be;
      unique case (size[1:0])
         2'b00:   be = 4'b0001 << off;
         2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/im_lsu_align.sv
// Sub-word load/store alignment: byte enables, store lane replication and load extraction
// with sign/zero extension. Only instantiated when IM_STAGE_SUBWORD_EN is defined.
module im_lsu_align
   import im_stage_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [1:0]       i_off,
   input  logic [2:0]       i_size,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [WIDTH-1:0] i_rdata,
   output logic [3:0]       o_be,
   output logic [WIDTH-1:0] o_wdata,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] shifted;

   always_comb begin
      o_be    = size_be(i_size, i_off);
      shifted = i_rdata >> {i_off, 3'b000};

      unique case (i_size[1:0])
         2'b00:   o_wdata = {4{i_wdata[7:0]}};
         2'b01:   o_wdata = {2{i_wdata[15:0]}};
         default: o_wdata = i_wdata;
      endcase

      unique case (i_size)
         F3_B:    o_rdata = {{24{shifted[7]}}, shifted[7:0]};
         F3_BU:   o_rdata = {24'd0, shifted[7:0]};
         F3_H:    o_rdata = {{16{shifted[15]}}, shifted[15:0]};
         F3_HU:   o_rdata = {16'd0, shifted[15:0]};
         default: o_rdata = i_rdata;
      endcase
   end

endmodule

// File: rtl/im_stage.sv
// RV32I memory stage: drives the valid/ready data-memory port, stalls the pipeline on wait
// states and registers write-back data into IM/IWB. Define IM_STAGE_SUBWORD_EN for byte/half.
module im_stage
   import im_stage_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned RF_ADD_W = 5
) (
   input  logic                i_clk,
   input  logic                i_rstn,
   input  logic [WIDTH-1:0]    i_im_alu_out,
   input  logic [WIDTH-1:0]    i_im_write_data,
   input  logic                i_im_mem_we,
   input  logic                i_im_mem_re,
   input  logic                i_im_rf_we_ctrl,
   input  logic [2:0]          i_im_rf_wb_src_ctrl,
   input  logic [WIDTH-1:0]    i_im_sx_data,
   input  logic [ADDR_W-1:0]   i_im_pc_plus_4,
   input  logic [RF_ADD_W-1:0] i_im_dst,
`ifdef IM_STAGE_SUBWORD_EN
   input  logic [2:0]          i_im_mem_size,
`endif
   input  logic                i_dmem_ready,
   input  logic [WIDTH-1:0]    i_dmem_rdata,
   output logic                o_dmem_req,
   output logic                o_dmem_we,
   output logic [WIDTH-1:0]    o_dmem_addr,
   output logic [WIDTH-1:0]    o_dmem_wdata,
   output logic [3:0]          o_dmem_be,
   output logic [WIDTH-1:0]    o_m_alu_out,
   output logic                o_stall,
   output logic [WIDTH-1:0]    o_iwb_alu_out,
   output logic [WIDTH-1:0]    o_iwb_mem_rdata,
   output logic [WIDTH-1:0]    o_iwb_sx_data,
   output logic [ADDR_W-1:0]   o_iwb_pc_plus_4,
   output logic                o_iwb_rf_we_ctrl,
   output logic [2:0]          o_iwb_rf_wb_src_ctrl,
   output logic [RF_ADD_W-1:0] o_iwb_dst
);

   im_state_e state_q, state_d;

   logic access, is_load, req, stall, load_done;
   logic [WIDTH-1:0] load_data;

   logic [WIDTH-1:0]    iwb_alu_q, iwb_alu_d;
   logic [WIDTH-1:0]    iwb_rdata_q, iwb_rdata_d;
   logic [WIDTH-1:0]    iwb_sx_q, iwb_sx_d;
   logic [ADDR_W-1:0]   iwb_pc_q, iwb_pc_d;
   logic                iwb_rf_we_q, iwb_rf_we_d;
   logic [2:0]          iwb_src_q, iwb_src_d;
   logic [RF_ADD_W-1:0] iwb_dst_q, iwb_dst_d;

   assign access  = i_im_mem_we | i_im_mem_re;
   assign is_load = i_im_mem_re & ~i_im_mem_we;

   always_comb begin
      state_d = state_q;
      req     = 1'b0;
      stall   = 1'b0;
      unique case (state_q)
         IM_IDLE: begin
            if (access) begin
               req = 1'b1;
               if (!i_dmem_ready) begin
                  stall   = 1'b1;
                  state_d = IM_WAIT;
               end
            end
         end
         IM_WAIT: begin
            req = 1'b1;
            if (i_dmem_ready) state_d = IM_IDLE;
            else              stall   = 1'b1;
         end
         default: state_d = IM_IDLE;
      endcase
   end

   // Reset must withdraw an in-flight request at once, not at the next edge
   assign o_dmem_req  = req & i_rstn;
   assign o_stall     = stall & i_rstn;
   assign o_dmem_we   = i_im_mem_we;
   assign o_dmem_addr = {i_im_alu_out[WIDTH-1:2], 2'b00};
   assign o_m_alu_out = i_im_alu_out;
   assign load_done   = req & i_dmem_ready & is_load;

`ifdef IM_STAGE_SUBWORD_EN
   im_lsu_align #(
      .WIDTH(WIDTH)
   ) u_align (
      .i_off  (i_im_alu_out[1:0]),
      .i_size (i_im_mem_size),
      .i_wdata(i_im_write_data),
      .i_rdata(i_dmem_rdata),
      .o_be   (o_dmem_be),
      .o_wdata(o_dmem_wdata),
      .o_rdata(load_data)
   );
`else
   assign o_dmem_be    = 4'hF;
   assign o_dmem_wdata = i_im_write_data;
   assign load_data    = i_dmem_rdata;
`endif

   // A stalled edge writes a bubble so each instruction reaches the RF exactly once
   always_comb begin
      iwb_alu_d   = i_im_alu_out;
      iwb_sx_d    = i_im_sx_data;
      iwb_pc_d    = i_im_pc_plus_4;
      iwb_src_d   = i_im_rf_wb_src_ctrl;
      iwb_rf_we_d = i_im_rf_we_ctrl & ~stall;
      iwb_dst_d   = stall ? '0 : i_im_dst;
      iwb_rdata_d = load_done ? load_data : iwb_rdata_q;
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q     <= IM_IDLE;
         iwb_alu_q   <= '0;
         iwb_rdata_q <= '0;
         iwb_sx_q    <= '0;
         iwb_pc_q    <= '0;
         iwb_rf_we_q <= 1'b0;
         iwb_src_q   <= '0;
         iwb_dst_q   <= '0;
      end else begin
         state_q     <= state_d;
         iwb_alu_q   <= iwb_alu_d;
         iwb_rdata_q <= iwb_rdata_d;
         iwb_sx_q    <= iwb_sx_d;
         iwb_pc_q    <= iwb_pc_d;
         iwb_rf_we_q <= iwb_rf_we_d;
         iwb_src_q   <= iwb_src_d;
         iwb_dst_q   <= iwb_dst_d;
      end
   end

   assign o_iwb_alu_out        = iwb_alu_q;
   assign o_iwb_mem_rdata      = iwb_rdata_q;
   assign o_iwb_sx_data        = iwb_sx_q;
   assign o_iwb_pc_plus_4      = iwb_pc_q;
   assign o_iwb_rf_we_ctrl     = iwb_rf_we_q;
   assign o_iwb_rf_wb_src_ctrl = iwb_src_q;
   assign o_iwb_dst            = iwb_dst_q;

endmodule

// File: tb/tb_im_stage.sv
// Scoreboard bench for im_stage: stimulus pushes expected memory requests and RF writes,
// a negedge monitor pops and compares. Sub-word cases run when IM_STAGE_SUBWORD_EN is defined.
module tb_im_stage;

   logic        i_clk = 1'b0;
   logic        i_rstn;
   logic [31:0] i_im_alu_out, i_im_write_data, i_im_sx_data, i_im_pc_plus_4;
   logic        i_im_mem_we, i_im_mem_re, i_im_rf_we_ctrl;
   logic [2:0]  i_im_rf_wb_src_ctrl;
   logic [4:0]  i_im_dst;
   logic [2:0]  mem_size;
   logic        i_dmem_ready;
   logic [31:0] i_dmem_rdata;
   logic        o_dmem_req, o_dmem_we, o_stall, o_iwb_rf_we_ctrl;
   logic [31:0] o_dmem_addr, o_dmem_wdata, o_m_alu_out;
   logic [3:0]  o_dmem_be;
   logic [31:0] o_iwb_alu_out, o_iwb_mem_rdata, o_iwb_sx_data, o_iwb_pc_plus_4;
   logic [2:0]  o_iwb_rf_wb_src_ctrl;
   logic [4:0]  o_iwb_dst;

   always #5 i_clk = ~i_clk;

   im_stage dut (
      .i_clk               (i_clk),
      .i_rstn              (i_rstn),
      .i_im_alu_out        (i_im_alu_out),
      .i_im_write_data     (i_im_write_data),
      .i_im_mem_we         (i_im_mem_we),
      .i_im_mem_re         (i_im_mem_re),
      .i_im_rf_we_ctrl     (i_im_rf_we_ctrl),
      .i_im_rf_wb_src_ctrl (i_im_rf_wb_src_ctrl),
      .i_im_sx_data        (i_im_sx_data),
      .i_im_pc_plus_4      (i_im_pc_plus_4),
      .i_im_dst            (i_im_dst),
`ifdef IM_STAGE_SUBWORD_EN
      .i_im_mem_size       (mem_size),
`endif
      .i_dmem_ready        (i_dmem_ready),
      .i_dmem_rdata        (i_dmem_rdata),
      .o_dmem_req          (o_dmem_req),
      .o_dmem_we           (o_dmem_we),
      .o_dmem_addr         (o_dmem_addr),
      .o_dmem_wdata        (o_dmem_wdata),
      .o_dmem_be           (o_dmem_be),
      .o_m_alu_out         (o_m_alu_out),
      .o_stall             (o_stall),
      .o_iwb_alu_out       (o_iwb_alu_out),
      .o_iwb_mem_rdata     (o_iwb_mem_rdata),
      .o_iwb_sx_data       (o_iwb_sx_data),
      .o_iwb_pc_plus_4     (o_iwb_pc_plus_4),
      .o_iwb_rf_we_ctrl    (o_iwb_rf_we_ctrl),
      .o_iwb_rf_wb_src_ctrl(o_iwb_rf_wb_src_ctrl),
      .o_iwb_dst           (o_iwb_dst)
   );

   typedef struct {
      logic        we;
      logic        chk_be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } req_t;

   typedef struct {
      logic [31:0] alu;
      logic [31:0] rdata;
      logic [31:0] sx;
      logic [31:0] pc;
      logic [2:0]  src;
      logic [4:0]  dst;
   } wb_t;

   req_t        req_q[$];
   wb_t         wb_q[$];
   int          errors = 0;
   int          checks = 0;
   logic        exp_stall = 1'b0;
   logic        bubble_exp = 1'b0;
   logic        mon_en = 1'b0;
   logic [31:0] model_rdata = 32'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: runs on negedge, away from the active edge
   always @(negedge i_clk) begin
      if (mon_en) begin
         req_t r;
         wb_t  w;
         check("stall", {31'd0, o_stall}, {31'd0, exp_stall});
         check("m_alu_out", o_m_alu_out, i_im_alu_out);
         if (o_dmem_req) begin
            if (req_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_req: got req=1 expected req=0");
            end else begin
               r = req_q[0];
               check("dmem_we", {31'd0, o_dmem_we}, {31'd0, r.we});
               check("dmem_addr", o_dmem_addr, r.addr);
               if (r.we) check("dmem_wdata", o_dmem_wdata, r.wdata);
               if (r.chk_be) check("dmem_be", {28'd0, o_dmem_be}, {28'd0, r.be});
               if (i_dmem_ready) void'(req_q.pop_front());
            end
         end
         if (bubble_exp) begin
            check("bubble_rf_we", {31'd0, o_iwb_rf_we_ctrl}, 32'd0);
            check("bubble_dst", {27'd0, o_iwb_dst}, 32'd0);
         end else if (o_iwb_rf_we_ctrl) begin
            if (wb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_rf_write: got rf_we=1 dst=%0d expected no write", o_iwb_dst);
            end else begin
               w = wb_q.pop_front();
               check("iwb_dst", {27'd0, o_iwb_dst}, {27'd0, w.dst});
               check("iwb_alu", o_iwb_alu_out, w.alu);
               check("iwb_rdata", o_iwb_mem_rdata, w.rdata);
               check("iwb_sx", o_iwb_sx_data, w.sx);
               check("iwb_pc", o_iwb_pc_plus_4, w.pc);
               check("iwb_src", {29'd0, o_iwb_rf_wb_src_ctrl}, {29'd0, w.src});
            end
         end
         bubble_exp = exp_stall;
      end
   end

   function automatic logic [31:0] load_value(input logic [2:0] size, input logic [1:0] off,
                                              input logic [31:0] rdata);
      logic [31:0] lane;
      lane = rdata >> (8 * off);
`ifdef IM_STAGE_SUBWORD_EN
      case (size)
         3'b000:  return 32'($signed(lane[7:0]));
         3'b100:  return {24'd0, lane[7:0]};
         3'b001:  return 32'($signed(lane[15:0]));
         3'b101:  return {16'd0, lane[15:0]};
         default: return rdata;
      endcase
`else
      if (size == 3'b111 && off == 2'b11) return rdata;
      return rdata;
`endif
   endfunction

   // Called one time unit after a rising edge; leaves the bench at the same phase
   task automatic issue(input logic we, input logic re, input logic rfwe, input logic [31:0] alu,
                        input logic [31:0] wd, input logic [4:0] dst, input logic [2:0] size,
                        input int nwait, input logic [31:0] rdata);
      req_t r;
      wb_t  w;
      logic acc;
      int   cycles;
      acc                 = we | re;
      i_im_mem_we         = we;
      i_im_mem_re         = re;
      i_im_rf_we_ctrl     = rfwe;
      i_im_alu_out        = alu;
      i_im_write_data     = wd;
      i_im_dst            = dst;
      i_im_sx_data        = $urandom;
      i_im_pc_plus_4      = $urandom;
      i_im_rf_wb_src_ctrl = 3'($urandom_range(0, 7));
      mem_size            = size;
      if (acc) begin
         r.we     = we;
         r.addr   = alu & 32'hFFFF_FFFC;
         r.chk_be = 1'b1;
         r.be     = 4'hF;
         r.wdata  = wd;
`ifdef IM_STAGE_SUBWORD_EN
         r.chk_be = we;
         if (size[1:0] == 2'b00) begin
            r.be    = 4'b0001 << alu[1:0];
            r.wdata = {4{wd[7:0]}};
         end else if (size[1:0] == 2'b01) begin
            r.be    = alu[1] ? 4'b1100 : 4'b0011;
            r.wdata = {2{wd[15:0]}};
         end
`endif
         req_q.push_back(r);
      end
      if (re && !we) model_rdata = load_value(size, alu[1:0], rdata);
      if (rfwe) begin
         w.alu   = alu;
         w.rdata = model_rdata;
         w.sx    = i_im_sx_data;
         w.pc    = i_im_pc_plus_4;
         w.src   = i_im_rf_wb_src_ctrl;
         w.dst   = dst;
         wb_q.push_back(w);
      end
      cycles = acc ? nwait : 0;
      for (int c = 0; c <= cycles; c++) begin
         i_dmem_ready = acc ? (c == nwait) : 1'($urandom_range(0, 1));
         i_dmem_rdata = (acc && c == nwait) ? rdata : $urandom;
         exp_stall    = acc && (c < nwait);
         @(posedge i_clk);
         #1;
      end
   endtask

   task automatic nop();
      issue(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 3'b010, 0, 32'd0);
   endtask

   initial begin
      i_rstn              = 1'b0;
      i_im_alu_out        = 32'h0000_0200;
      i_im_write_data     = 32'd0;
      i_im_mem_we         = 1'b0;
      i_im_mem_re         = 1'b1;
      i_im_rf_we_ctrl     = 1'b1;
      i_im_rf_wb_src_ctrl = 3'd0;
      i_im_sx_data        = 32'd0;
      i_im_pc_plus_4      = 32'd0;
      i_im_dst            = 5'd9;
      mem_size            = 3'b010;
      i_dmem_ready        = 1'b0;
      i_dmem_rdata        = 32'hFFFF_FFFF;
      #7;
      check("rst_req", {31'd0, o_dmem_req}, 32'd0);
      check("rst_stall", {31'd0, o_stall}, 32'd0);
      check("rst_iwb_rf_we", {31'd0, o_iwb_rf_we_ctrl}, 32'd0);
      check("rst_iwb_dst", {27'd0, o_iwb_dst}, 32'd0);
      check("rst_iwb_alu", o_iwb_alu_out, 32'd0);
      check("rst_iwb_rdata", o_iwb_mem_rdata, 32'd0);
      check("rst_iwb_pc", o_iwb_pc_plus_4, 32'd0);
      i_im_mem_re     = 1'b0;
      i_im_rf_we_ctrl = 1'b0;
      #5 i_rstn = 1'b1;
      @(posedge i_clk);
      #1 mon_en = 1'b1;

      // Zero-wait store, multi-wait load, plain ALU op, simultaneous we/re
      issue(1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 5'd0, 3'b010, 0, 32'h0);
      issue(1'b0, 1'b1, 1'b1, 32'h0000_0200, 32'h0, 5'd7, 3'b010, 3, 32'h1234_5678);
      issue(1'b0, 1'b0, 1'b1, 32'h0000_0055, 32'h0, 5'd3, 3'b010, 0, 32'h0);
      issue(1'b1, 1'b1, 1'b1, 32'h0000_0300, 32'hCAFE_F00D, 5'd4, 3'b010, 1, 32'hAAAA_5555);

      // Reset asserted while the FSM waits on a load
      i_im_mem_we     = 1'b0;
      i_im_mem_re     = 1'b1;
      i_im_rf_we_ctrl = 1'b1;
      i_im_dst        = 5'd12;
      i_im_alu_out    = 32'h0000_0400;
      i_dmem_ready    = 1'b0;
      r_push_wait_load();
      exp_stall = 1'b1;
      @(posedge i_clk);
      #2;
      i_rstn    = 1'b0;
      exp_stall = 1'b0;
      #1;
      check("rstwait_req", {31'd0, o_dmem_req}, 32'd0);
      check("rstwait_stall", {31'd0, o_stall}, 32'd0);
      check("rstwait_iwb_rf_we", {31'd0, o_iwb_rf_we_ctrl}, 32'd0);
      check("rstwait_iwb_dst", {27'd0, o_iwb_dst}, 32'd0);
      check("rstwait_iwb_alu", o_iwb_alu_out, 32'd0);
      check("rstwait_iwb_rdata", o_iwb_mem_rdata, 32'd0);
      check("rstwait_iwb_sx", o_iwb_sx_data, 32'd0);
      req_q.delete();
      model_rdata     = 32'd0;
      i_im_mem_re     = 1'b0;
      i_im_rf_we_ctrl = 1'b0;
      @(negedge i_clk);
      #1 i_rstn = 1'b1;
      @(posedge i_clk);
      #1;
      issue(1'b0, 1'b1, 1'b1, 32'h0000_0404, 32'h0, 5'd13, 3'b010, 2, 32'h0BAD_F00D);

`ifdef IM_STAGE_SUBWORD_EN
      issue(1'b0, 1'b1, 1'b1, 32'h0000_0003, 32'h0, 5'd5, 3'b000, 0, 32'h80AA_BBCC);
      issue(1'b0, 1'b1, 1'b1, 32'h0000_0003, 32'h0, 5'd6, 3'b100, 1, 32'h80AA_BBCC);
      issue(1'b1, 1'b0, 1'b0, 32'h0000_0002, 32'h1234_ABCD, 5'd0, 3'b001, 0, 32'h0);
`endif

      for (int i = 0; i < 80; i++) begin
         logic we, re;
         we = ($urandom_range(0, 3) == 0);
         re = ($urandom_range(0, 2) == 0);
         issue(we, re, 1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom_range(0, 31)),
               3'b010, $urandom_range(0, 3), $urandom);
      end
      nop();
      nop();
      check("req_queue_drained", req_q.size(), 32'd0);
      check("wb_queue_drained", wb_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   task automatic r_push_wait_load();
      req_t r;
      r.we     = 1'b0;
      r.chk_be = 1'b0;
      r.addr   = 32'h0000_0400;
      r.wdata  = 32'd0;
      r.be     = 4'hF;
      req_q.push_back(r);
   endtask

endmodule
